// File: rtl/cv32e40x_xif_aes_ctrl_if.sv
// Bundle of the eXtension-interface channels (issue, commit, result) and the
// AES32 functional-unit channel used by cv32e40x_xif_aes_ctrl.
//   slave  : the controller side (takes issue/commit, drives FU operands and results)
//   master : the core / FU side
// Signal names keep the controller's _i/_o view, so both sides share one naming.
interface cv32e40x_xif_aes_ctrl_if #(
    parameter int unsigned X_ID_WIDTH  = 4,
    parameter int unsigned X_RFR_WIDTH = 32
);
    // issue channel
    logic                   issue_valid_i;
    logic                   issue_ready_o;
    logic [31:0]            issue_instr_i;
    logic [X_ID_WIDTH-1:0]  issue_id_i;
    logic [X_RFR_WIDTH-1:0] issue_rs1_i;
    logic [X_RFR_WIDTH-1:0] issue_rs2_i;
    logic [1:0]             issue_rs_valid_i;
    logic                   issue_accept_o;
    logic                   issue_writeback_o;
    // commit channel
    logic                   commit_valid_i;
    logic [X_ID_WIDTH-1:0]  commit_id_i;
    logic                   commit_kill_i;
    // functional unit channel
    logic                   fu_valid_o;
    logic [X_RFR_WIDTH-1:0] fu_rs1_o;
    logic [X_RFR_WIDTH-1:0] fu_rs2_o;
    logic [1:0]             fu_bs_o;
    logic [3:0]             fu_op_o;
    logic                   fu_ready_i;
    logic [X_RFR_WIDTH-1:0] fu_rd_i;
    // result channel
    logic                   result_valid_o;
    logic                   result_ready_i;
    logic [X_ID_WIDTH-1:0]  result_id_o;
    logic [X_RFR_WIDTH-1:0] result_data_o;
    logic [4:0]             result_rd_o;
    logic                   result_we_o;

    modport slave (
        input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs1_i, issue_rs2_i,
               issue_rs_valid_i, commit_valid_i, commit_id_i, commit_kill_i,
               fu_ready_i, fu_rd_i, result_ready_i,
        output issue_ready_o, issue_accept_o, issue_writeback_o,
               fu_valid_o, fu_rs1_o, fu_rs2_o, fu_bs_o, fu_op_o,
               result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o
    );

    modport master (
        output issue_valid_i, issue_instr_i, issue_id_i, issue_rs1_i, issue_rs2_i,
               issue_rs_valid_i, commit_valid_i, commit_id_i, commit_kill_i,
               fu_ready_i, fu_rd_i, result_ready_i,
        input  issue_ready_o, issue_accept_o, issue_writeback_o,
               fu_valid_o, fu_rs1_o, fu_rs2_o, fu_bs_o, fu_op_o,
               result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o
    );
endinterface

// File: rtl/cv32e40x_xif_aes_ctrl.sv
// Sequencer between the eXtension interface and a single-cycle AES32 datapath.
// Offloaded AES32 instructions are tracked in-order in a DEPTH-entry queue;
// each head entry waits for its commit or kill, committed entries are sent to
// the FU, and results are returned one at a time under valid/ready.
// Ports:
//   clk   : clock
//   rst_n : asynchronous reset, active low
//   xif   : issue / commit / FU / result channels (slave view)
//
// Dispatch FSM
//   state  | meaning
//   S_IDLE | waiting for head commit; drops one killed head per cycle
//   S_EXEC | head operands on the FU, waiting for fu_ready_i
//   S_RESP | result held on the result channel until result_ready_i
module cv32e40x_xif_aes_ctrl #(
    parameter int unsigned X_ID_WIDTH  = 4,
    parameter int unsigned X_RFR_WIDTH = 32,
    parameter int unsigned DEPTH       = 4,
    parameter logic [6:0]  AES_OPCODE  = 7'b0110011
) (
    input  logic                     clk,
    input  logic                     rst_n,
    cv32e40x_xif_aes_ctrl_if.slave   xif
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {E_PEND, E_CMT, E_KILL} ent_st_e;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

    function automatic logic [3:0] op_of(input logic [4:0] f5);
        case (f5)
            5'b10001: op_of = 4'b0001;   // esi
            5'b10011: op_of = 4'b0010;   // esmi
            5'b10101: op_of = 4'b0100;   // dsi
            5'b10111: op_of = 4'b1000;   // dsmi
            default:  op_of = 4'b0000;
        endcase
    endfunction

    // queue storage
    logic [X_ID_WIDTH-1:0]  q_id  [DEPTH];
    logic [X_RFR_WIDTH-1:0] q_rs1 [DEPTH];
    logic [X_RFR_WIDTH-1:0] q_rs2 [DEPTH];
    logic [6:0]             q_f7  [DEPTH];
    logic [4:0]             q_rd  [DEPTH];
    ent_st_e                q_st  [DEPTH];
    logic [DEPTH-1:0]       q_vld;

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             full, empty;
    logic             rdy_en_q;

    state_e state_q, state_d;
    logic   push, pop;
    logic   is_aes;
    ent_st_e new_st;

    logic [X_ID_WIDTH-1:0]  res_id_q;
    logic [X_RFR_WIDTH-1:0] res_data_q;
    logic [4:0]             res_rd_q;

    // instr[24:15] carry the core's register indices; the operand values
    // arrive separately, so those bits are not needed here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^xif.issue_instr_i[24:15];

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    assign is_aes = (xif.issue_instr_i[6:0] == AES_OPCODE) &&
                    (xif.issue_instr_i[14:12] == 3'b000) &&
                    (op_of(xif.issue_instr_i[29:25]) != 4'b0000);

    // rdy_en_q keeps ready low while in reset and comes up on the first edge after release.
    assign xif.issue_ready_o     = rdy_en_q && !full &&
                                   !(is_aes && (xif.issue_rs_valid_i != 2'b11));
    assign xif.issue_accept_o    = xif.issue_valid_i && xif.issue_ready_o && is_aes;
    assign xif.issue_writeback_o = xif.issue_accept_o;

    assign push = xif.issue_accept_o;

    // A commit/kill arriving together with its own issue is folded into the new entry.
    always_comb begin
        new_st = E_PEND;
        if (xif.commit_valid_i && (xif.commit_id_i == xif.issue_id_i)) begin
            new_st = xif.commit_kill_i ? E_KILL : E_CMT;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_id[wr_ptr]  <= xif.issue_id_i;
            q_rs1[wr_ptr] <= xif.issue_rs1_i;
            q_rs2[wr_ptr] <= xif.issue_rs2_i;
            q_f7[wr_ptr]  <= xif.issue_instr_i[31:25];
            q_rd[wr_ptr]  <= xif.issue_instr_i[11:7];
        end
    end

    // Only PEND entries react to commit, so the head already in EXEC/RESP
    // (state CMT) ignores a late kill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_vld <= '0;
            for (int i = 0; i < DEPTH; i++) q_st[i] <= E_PEND;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (xif.commit_valid_i && q_vld[i] && (q_st[i] == E_PEND) &&
                    (q_id[i] == xif.commit_id_i)) begin
                    q_st[i] <= xif.commit_kill_i ? E_KILL : E_CMT;
                end
            end
            if (pop)  q_vld[rd_ptr] <= 1'b0;
            if (push) begin
                q_vld[wr_ptr] <= 1'b1;
                q_st[wr_ptr]  <= new_st;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    if (q_st[rd_ptr] == E_KILL)     pop = 1'b1;
                    else if (q_st[rd_ptr] == E_CMT) state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (xif.fu_ready_i) begin
                    pop     = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (xif.result_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_id_q   <= '0;
            res_data_q <= '0;
            res_rd_q   <= '0;
        end else if ((state_q == S_EXEC) && xif.fu_ready_i) begin
            res_id_q   <= q_id[rd_ptr];
            res_data_q <= xif.fu_rd_i;
            res_rd_q   <= q_rd[rd_ptr];
        end
    end

    // FU and result buses are forced to zero outside their active state so
    // nothing stale is visible in reset or idle.
    assign xif.fu_valid_o = (state_q == S_EXEC);
    assign xif.fu_rs1_o   = xif.fu_valid_o ? q_rs1[rd_ptr]             : '0;
    assign xif.fu_rs2_o   = xif.fu_valid_o ? q_rs2[rd_ptr]             : '0;
    assign xif.fu_bs_o    = xif.fu_valid_o ? q_f7[rd_ptr][6:5]         : 2'b00;
    assign xif.fu_op_o    = xif.fu_valid_o ? op_of(q_f7[rd_ptr][4:0]) : 4'b0000;

    assign xif.result_valid_o = (state_q == S_RESP);
    assign xif.result_id_o    = xif.result_valid_o ? res_id_q   : '0;
    assign xif.result_data_o  = xif.result_valid_o ? res_data_q : '0;
    assign xif.result_rd_o    = xif.result_valid_o ? res_rd_q   : 5'd0;
    assign xif.result_we_o    = xif.result_valid_o && (res_rd_q != 5'd0);
endmodule
